// File: rtl/apb_pkg.sv
// apb_pkg: types and constants shared by the APB bridge and APB slave peripherals.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
    localparam int APB_DW = 32;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps a byte address onto one slave slot of the peripheral window.
//  addr_i  byte address
//  hit_o   address lies inside [BASE_ADDR, BASE_ADDR + NUM_SLV<<SLV_BITS)
//  idx_o   slot index of the address
//  sel_o   one-hot slave select, all zero on a miss
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          SLV_BITS  = 12,
    parameter int          NUM_SLV   = 4,
    parameter int          IW        = idx_w(NUM_SLV)
) (
    input  logic [31:0]        addr_i,
    output logic               hit_o,
    output logic [IW-1:0]      idx_o,
    output logic [NUM_SLV-1:0] sel_o
);
    localparam logic [32:0] SPAN = 33'(NUM_SLV) << SLV_BITS;
    logic [31:0] off;
    always_comb begin
        off   = addr_i - BASE_ADDR;
        // addresses below the base wrap to large offsets, but are excluded explicitly anyway
        hit_o = (addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);
        idx_o = off[SLV_BITS +: IW];
        sel_o = hit_o ? NUM_SLV'(1) << idx_o : '0;
    end
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns valid/ready requests into APB SETUP/ACCESS transfers.
//  PCLK/PRESET                          clock, async active-high reset
//  req_valid/req_ready/req_write/req_addr/req_wdata   request side
//  resp_valid/resp_err/resp_rdata       one-cycle response strobe
//  PADDR/PWRITE/PENABLE/PWDATA/PSEL     APB outputs (all registered)
//  PRDATA/PREADY                        per-slave APB inputs, slave i at slice i
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          SLV_BITS  = 12,
    parameter int          TIMEOUT   = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic                      resp_err,
    output logic [31:0]               resp_rdata,
    output logic [SLV_BITS-1:0]       PADDR,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [31:0]               PWDATA,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*APB_DW-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY
);
    localparam int IW = idx_w(NUM_SLV);
    localparam int CW = $clog2(TIMEOUT) + 1;

    apb_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [IW-1:0]      idx_q;
    logic               hit;
    logic [IW-1:0]      idx;
    logic [NUM_SLV-1:0] sel;
    logic               rdy;
    logic [APB_DW-1:0]  rdat;

    apb_addr_decoder #(
        .BASE_ADDR(BASE_ADDR),
        .SLV_BITS (SLV_BITS),
        .NUM_SLV  (NUM_SLV),
        .IW       (IW)
    ) u_dec (
        .addr_i(req_addr),
        .hit_o (hit),
        .idx_o (idx),
        .sel_o (sel)
    );

    assign req_ready = state_q == IDLE;
    // only the addressed slave is observed
    assign rdy       = PREADY[idx_q];
    assign rdat      = PRDATA[{idx_q, 5'd0} +: APB_DW];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            PSEL       <= '0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            case (state_q)
                IDLE: if (req_valid) begin
                    if (hit) begin
                        state_q <= SETUP;
                        PSEL    <= sel;
                        // low bits of (addr - base) only depend on the low bits of each operand
                        PADDR   <= req_addr[SLV_BITS-1:0] - BASE_ADDR[SLV_BITS-1:0];
                        PWRITE  <= req_write;
                        PWDATA  <= req_wdata;
                        idx_q   <= idx;
                        cnt_q   <= '0;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: if (rdy) begin
                    state_q    <= IDLE;
                    PSEL       <= '0;
                    PENABLE    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= PWRITE ? '0 : rdat;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_q    <= IDLE;
                    PSEL       <= '0;
                    PENABLE    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench for the APB bridge with registered-PREADY slave models.
module tb_apb_master_bridge;
    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic           req_valid, req_ready, req_write;
    logic [31:0]    req_addr, req_wdata;
    logic           resp_valid, resp_err;
    logic [31:0]    resp_rdata;
    logic [11:0]    PADDR;
    logic           PWRITE, PENABLE;
    logic [31:0]    PWDATA;
    logic [NS-1:0]  PSEL;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0]  PREADY;
    logic [NS-1:0]  en;

    typedef struct packed {logic err; logic chk; logic [31:0] rd;} exp_t;
    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int resp_cnt = 0;
    int last_resp_cyc = 0;

    apb_master_bridge dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    assign PRDATA = {32'hA7, 32'hA6, 32'hA5, 32'hA4};

    // each enabled slave answers one cycle after it sees its ACCESS phase
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) PREADY <= '0;
        else for (int i = 0; i < NS; i++) PREADY[i] <= en[i] && PSEL[i] && PENABLE && !PREADY[i];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic w, input logic [31:0] a);
        exp_t e;
        logic [31:0] off;
        logic hit;
        int idx;
        off   = a - BASE;
        hit   = (a >= BASE) && (off < 32'(NS * 4096));
        idx   = int'(off[13:12]);
        e.err = !hit || !en[idx];
        e.chk = !hit || en[idx];
        e.rd  = (hit && en[idx] && !w) ? 32'hA4 + 32'(idx) : 32'h0;
        return e;
    endfunction

    always @(negedge PCLK) begin
        if (!PRESET && resp_valid) begin
            exp_t e;
            resp_cnt++;
            last_resp_cyc = cyc;
            if (q.size() == 0) check("sb_unexpected_resp", 1, 0);
            else begin
                e = q.pop_front();
                check("resp_err", resp_err, e.err);
                if (e.chk) check("resp_rdata", resp_rdata, e.rd);
            end
        end
    end

    logic [48:0] prev_bus;
    logic        pen_prev = 1'b0;
    always @(negedge PCLK) begin
        if (PENABLE && pen_prev) check("access_stable", {PSEL, PADDR, PWRITE, PWDATA}, prev_bus);
        if (pen_prev && !PENABLE) check("psel_gap", PSEL, 0);
        prev_bus = {PSEL, PADDR, PWRITE, PWDATA};
        pen_prev = PENABLE;
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int acc, output logic rv);
        int n;
        n = 0;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        rv = resp_valid;
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            acc = cyc;
        end else begin
            q.push_back(model(w, a));
            @(posedge PCLK);
            #1 acc = cyc;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (q.size() != 0) begin
            check("drain_timeout", 64'(q.size()), 0);
            q.delete();
        end
        @(negedge PCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int   acc, acc2, n, rc;
        logic rv;
        PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; en = '1;
        repeat (3) @(negedge PCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_apb_regs", {PWRITE, PADDR, PWDATA}, 0);
        check("rst_resp", {resp_valid, resp_err, resp_rdata}, 0);
        check("rst_ready", req_ready, 1);
        PRESET = 1'b0;
        @(negedge PCLK);

        // 1: write to slave0
        send(1'b1, 32'h1000_0000, 32'hFF, acc, rv);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("t1_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {4'b0001, 1'b0, 1'b1, 12'h000, 32'hFF});
        check("t1_ready_low", req_ready, 0);
        @(negedge PCLK);
        check("t1_access", {PSEL, PENABLE}, {4'b0001, 1'b1});
        drain();
        check("t1_latency", 64'(last_resp_cyc - acc), 3);

        // 2: read from slave1
        send(1'b0, 32'h1000_1004, 32'h0, acc, rv);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("t2_setup", {PSEL, PWRITE, PADDR}, {4'b0010, 1'b0, 12'h004});
        drain();

        // 3: out-of-window addresses, above, below and just past the last slot
        send(1'b0, 32'h2000_0000, 32'h0, acc, rv);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("t3_no_psel", PSEL, 0);
        check("t3_resp_next", resp_valid, 1);
        drain();
        send(1'b0, 32'h0FFF_FFFC, 32'h0, acc, rv);
        req_valid = 1'b0;
        drain();
        send(1'b0, 32'h1000_4000, 32'h0, acc, rv);
        req_valid = 1'b0;
        drain();

        // 4: slave2 never ready, then a normal read to the last slot
        en[2] = 1'b0;
        send(1'b0, 32'h1000_2008, 32'h0, acc, rv);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("t4_psel", PSEL, 4'b0100);
        n = 0;
        @(negedge PCLK);
        while (PENABLE && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        check("t4_access_cycles", 64'(n), 16);
        check("t4_psel_drop", PSEL, 0);
        drain();
        en[2] = 1'b1;
        send(1'b0, 32'h1000_3FFC, 32'h0, acc, rv);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("t4_next_setup", {PSEL, PADDR}, {4'b1000, 12'hFFC});
        drain();

        // 5: back-to-back writes with req_valid held
        send(1'b1, 32'h1000_0010, 32'h11, acc, rv);
        send(1'b1, 32'h1000_3008, 32'h22, acc2, rv);
        req_valid = 1'b0;
        check("t5_accept_in_resp", rv, 1);
        check("t5_gap", 64'(acc2 - acc), 4);
        @(negedge PCLK);
        check("t5_second_setup", {PSEL, PADDR, PWDATA}, {4'b1000, 12'h008, 32'h22});
        drain();

        // 6: reset during ACCESS
        en[2] = 1'b0;
        send(1'b1, 32'h1000_2000, 32'h33, acc, rv);
        req_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        check("t6_in_access", PENABLE, 1);
        rc = resp_cnt;
        PRESET = 1'b1;
        #1;
        check("t6_async_drop", {PSEL, PENABLE}, 0);
        q.delete();
        @(negedge PCLK);
        PRESET = 1'b0;
        en[2] = 1'b1;
        repeat (5) @(negedge PCLK);
        check("t6_no_resp", 64'(resp_cnt), 64'(rc));
        check("t6_ready", req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
